// File: rtl/idu_pipe_if.sv
// Decode-stage bus: the IFU-side request (inst/in_pc/valid/flush) and the EXU-side decoded bundle.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Modports: master = producer/consumer around the stage (IFU+EXU or a bench),
//           slave  = the decode stage itself.
interface idu_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int XLEN       = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [XLEN-1:0]       in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [XLEN-1:0]       imm;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [6:0]            opcode7;
    logic [2:0]            opcode3;
    logic [6:0]            funct7;
    logic [2:0]            fmt;
    logic                  rd_we;
    logic                  illegal;

    modport master (
        output flush, in_valid, inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, imm, rd, rs1, rs2,
               opcode7, opcode3, funct7, fmt, rd_we, illegal
    );

    modport slave (
        input  flush, in_valid, inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, imm, rd, rs1, rs2,
               opcode7, opcode3, funct7, fmt, rd_we, illegal
    );
endinterface

// File: rtl/idu_pipe.sv
// RV32I decode stage: format, sign-extended immediate, register/funct fields, rd write-enable, illegal flag.
// Latency: 1 cycle, full throughput while out_ready is held high.
// Backpressure: holds the bundle bit-stable and deasserts in_ready while out_valid && !out_ready; flush empties the stage.
// Ports: clk, rst (synchronous, active-high); bus (idu_pipe_if.slave) carries the input request,
//        flush, and the registered decoded bundle. Every bundle output comes straight from a register.
module idu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic      clk,
    input  logic      rst,
    idu_pipe_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("idu_pipe: DATA_WIDTH must be 32");
        end
        if (XLEN < 32) begin : g_bad_xlen
            $error("idu_pipe: XLEN must be >= 32");
        end
    endgenerate

    logic [31:0]        w_inst;
    logic [2:0]         w_fmt;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_illegal;
    logic               w_rd_we;
    logic               w_in_ready;
    logic               w_accept;

    logic               r_out_valid;
    logic [XLEN-1:0]    r_out_pc;
    logic [XLEN-1:0]    r_imm;
    logic [4:0]         r_rd;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [6:0]         r_opcode7;
    logic [2:0]         r_opcode3;
    logic [6:0]         r_funct7;
    logic [2:0]         r_fmt;
    logic               r_rd_we;
    logic               r_illegal;

    assign w_inst = bus.inst[31:0];

    always_comb begin
        w_fmt     = FMT_ILL;
        w_imm32   = '0;
        w_illegal = 1'b1;
        // Every valid RV32I opcode ends in 2'b11, so compressed-looking words fall into default.
        case (w_inst[6:0])
            7'b0110011: begin
                w_fmt     = FMT_R;
                w_illegal = 1'b0;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w_fmt     = FMT_I;
                w_imm32   = {{20{w_inst[31]}}, w_inst[31:20]};
                w_illegal = 1'b0;
            end
            7'b0100011: begin
                w_fmt     = FMT_S;
                w_imm32   = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
                w_illegal = 1'b0;
            end
            7'b1100011: begin
                w_fmt     = FMT_B;
                w_imm32   = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
                w_illegal = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                w_fmt     = FMT_U;
                w_imm32   = {w_inst[31:12], 12'b0};
                w_illegal = 1'b0;
            end
            7'b1101111: begin
                w_fmt     = FMT_J;
                w_imm32   = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
                w_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Sized cast of a signed operand sign-extends the 32-bit immediate up to XLEN.
    assign w_imm   = XLEN'(w_imm32);
    assign w_rd_we = !w_illegal && (w_fmt != FMT_S) && (w_fmt != FMT_B) && (w_inst[11:7] != 5'd0);

    assign w_in_ready = !bus.flush && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_opcode7   <= '0;
            r_opcode3   <= '0;
            r_funct7    <= '0;
            r_fmt       <= '0;
            r_rd_we     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            // Data registers keep their contents; only the valid bit is cleared.
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= bus.in_pc;
            r_imm       <= w_imm;
            r_rd        <= w_inst[11:7];
            r_rs1       <= w_inst[19:15];
            r_rs2       <= w_inst[24:20];
            r_opcode7   <= w_inst[6:0];
            r_opcode3   <= w_inst[14:12];
            r_funct7    <= w_inst[31:25];
            r_fmt       <= w_fmt;
            r_rd_we     <= w_rd_we;
            r_illegal   <= w_illegal;
        end else if (bus.out_ready) begin
            // Drain: bundle consumed and nothing new arrived.
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_out_pc;
    assign bus.imm       = r_imm;
    assign bus.rd        = r_rd;
    assign bus.rs1       = r_rs1;
    assign bus.rs2       = r_rs2;
    assign bus.opcode7   = r_opcode7;
    assign bus.opcode3   = r_opcode3;
    assign bus.funct7    = r_funct7;
    assign bus.fmt       = r_fmt;
    assign bus.rd_we     = r_rd_we;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: a 32-bit and a 64-bit instance driven with identical stimulus.
// Inputs change on the falling edge; outputs are compared on the falling edge after the capture edge.
module tb_idu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [63:0] in_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idu_pipe_if #(.DATA_WIDTH(32), .XLEN(32)) if32 ();
    idu_pipe_if #(.DATA_WIDTH(32), .XLEN(64)) if64 ();

    assign if32.flush     = flush;
    assign if32.in_valid  = in_valid;
    assign if32.out_ready = out_ready;
    assign if32.inst      = inst;
    assign if32.in_pc     = in_pc[31:0];
    assign if64.flush     = flush;
    assign if64.in_valid  = in_valid;
    assign if64.out_ready = out_ready;
    assign if64.inst      = inst;
    assign if64.in_pc     = in_pc;

    idu_pipe #(.DATA_WIDTH(32), .XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    idu_pipe #(.DATA_WIDTH(32), .XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single cycle; returns on the falling edge after capture.
    task automatic send(input logic [31:0] i, input logic [63:0] pc);
        in_valid = 1'b1;
        inst     = i;
        in_pc    = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [31:0] s_inst [4];
    logic [31:0] s_pc   [4];
    logic [5:0]  pat;
    int          acc_idx;
    int          del_idx;
    int          m_item;
    bit          m_vld;
    bit          m_acc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", if32.out_valid, 0);
        chk("rst_fmt",       if32.fmt,       0);
        chk("rst_imm",       if32.imm,       0);
        chk("rst_out_pc",    if32.out_pc,    0);
        chk("rst_rd_we",     if32.rd_we,     0);
        chk("rst_illegal",   if32.illegal,   0);
        chk("rst_in_ready",  if32.in_ready,  1);
        rst = 1'b0;

        // I-type: addi x1,x0,-1
        send(32'hFFF00093, 64'h100);
        chk("i_valid", if32.out_valid, 1);
        chk("i_imm",   if32.imm,       32'hFFFFFFFF);
        chk("i_rd",    if32.rd,        1);
        chk("i_rs1",   if32.rs1,       0);
        chk("i_fmt",   if32.fmt,       1);
        chk("i_rd_we", if32.rd_we,     1);
        chk("i_pc",    if32.out_pc,    32'h100);
        chk("i_imm64", if64.imm,       64'hFFFFFFFFFFFFFFFF);

        // S-type: sw x2,8(x1)
        send(32'h0020A423, 64'h104);
        chk("s_imm",   if32.imm,     32'h8);
        chk("s_rs1",   if32.rs1,     1);
        chk("s_rs2",   if32.rs2,     2);
        chk("s_op3",   if32.opcode3, 2);
        chk("s_fmt",   if32.fmt,     2);
        chk("s_rd_we", if32.rd_we,   0);

        // B-type: beq -4
        send(32'hFE000EE3, 64'h108);
        chk("b_imm", if32.imm, 32'hFFFFFFFC);
        chk("b_fmt", if32.fmt, 3);

        // U-type: lui x5,0x12345
        send(32'h123452B7, 64'h10C);
        chk("u_imm",   if32.imm, 32'h12345000);
        chk("u_rd",    if32.rd,  5);
        chk("u_fmt",   if32.fmt, 4);
        chk("u_imm64", if64.imm, 64'h0000000012345000);

        // J-type: jal x1,+2048
        send(32'h001000EF, 64'h110);
        chk("j_imm",   if32.imm,   32'h800);
        chk("j_fmt",   if32.fmt,   5);
        chk("j_rd_we", if32.rd_we, 1);

        // R-type: add x3,x1,x2
        send(32'h002081B3, 64'h114);
        chk("r_fmt",   if32.fmt,     0);
        chk("r_imm",   if32.imm,     0);
        chk("r_rd",    if32.rd,      3);
        chk("r_f7",    if32.funct7,  0);
        chk("r_op7",   if32.opcode7, 7'h33);
        chk("r_rd_we", if32.rd_we,   1);

        // nop writes x0: legal I-type without rd write
        send(32'h00000013, 64'h118);
        chk("nop_fmt",   if32.fmt,   1);
        chk("nop_rd_we", if32.rd_we, 0);

        // Illegal encodings: all-zero word and opcode 0x7F
        send(32'h00000000, 64'h11C);
        chk("ill0_fmt", if32.fmt,     7);
        chk("ill0_ill", if32.illegal, 1);
        chk("ill0_imm", if32.imm,     0);
        chk("ill0_we",  if32.rd_we,   0);
        send(32'hFFFFFFFF, 64'h120);
        chk("ill7f_fmt", if32.fmt,     7);
        chk("ill7f_ill", if32.illegal, 1);
        chk("ill7f_imm", if32.imm,     0);
        chk("ill7f_we",  if32.rd_we,   0);
        chk("ill7f_op7", if32.opcode7, 7'h7F);

        // Mid-stream reset with an instruction still offered
        send(32'h002081B3, 64'h124);
        rst = 1'b1; in_valid = 1'b1; inst = 32'hFFF00093;
        repeat (2) @(negedge clk);
        chk("mrst_valid", if32.out_valid, 0);
        chk("mrst_imm",   if32.imm,       0);
        chk("mrst_rd",    if32.rd,        0);
        chk("mrst_fmt",   if32.fmt,       0);
        chk("mrst_pc",    if32.out_pc,    0);
        rst = 1'b0; in_valid = 1'b0;

        // Flush while stalled: out_valid drops and the offered word is not captured
        out_ready = 1'b0;
        send(32'h00000113, 64'h300);
        chk("fl_pre_valid", if32.out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; inst = 32'h00000193; in_pc = 64'h304;
        #1;
        chk("fl_in_ready", if32.in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", if32.out_valid, 0);
        chk("fl_pc",    if32.out_pc,    32'h300);
        chk("fl_rd",    if32.rd,        2);
        @(negedge clk);
        chk("fl_valid2", if32.out_valid, 0);
        out_ready = 1'b1;

        // Backpressure: 4 back-to-back instructions, out_ready 1,0,0,1,1,1 then 1
        s_inst[0] = 32'h00000093; s_pc[0] = 32'h200;
        s_inst[1] = 32'h00000113; s_pc[1] = 32'h204;
        s_inst[2] = 32'h00000193; s_pc[2] = 32'h208;
        s_inst[3] = 32'h00000213; s_pc[3] = 32'h20C;
        pat = 6'b111001;
        acc_idx = 0; del_idx = 0; m_vld = 1'b0; m_item = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c < 6) ? pat[c] : 1'b1;
            in_valid  = (acc_idx < 4);
            if (acc_idx < 4) begin
                inst  = s_inst[acc_idx];
                in_pc = {32'h0, s_pc[acc_idx]};
            end
            #1;
            chk("bp_valid",    if32.out_valid, m_vld);
            chk("bp_in_ready", if32.in_ready,  !m_vld || out_ready);
            if (m_vld) begin
                chk("bp_hold_pc", if32.out_pc, s_pc[m_item]);
                chk("bp_hold_rd", if32.rd,     m_item + 1);
            end
            if (if32.out_valid && out_ready) begin
                if (del_idx < 4) chk("bp_order_pc", if32.out_pc, s_pc[del_idx]);
                del_idx++;
            end
            m_acc = in_valid && (!m_vld || out_ready);
            if (m_acc) begin
                m_item = acc_idx;
                acc_idx++;
                m_vld = 1'b1;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_delivered", del_idx, 4);
        chk("bp_accepted",  acc_idx, 4);
        chk("bp_end_valid", if32.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Parametrised, handshaked successor to the single-format decode stage.
- Decodes all RV32I base formats (R/I/S/B/U/J): sign-extended immediate of width XLEN, register fields, funct fields, format code, write-enable and illegal-instruction flag.
- Sits between the IFU and EXU as one registered pipeline stage.
- Uses valid/ready backpressure and a synchronous flush for redirects.

Parameters:
- DATA_WIDTH, 32, instruction width; only 32 is supported (elaboration error otherwise).
- XLEN, 32, datapath width for imm and PC; must be >= 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard stage contents and the current input
- in_valid  in  1  inst/in_pc valid
- in_ready  out  1  stage can accept this cycle
- inst  in  DATA_WIDTH  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_pc  out  XLEN  registered PC
- imm  out  XLEN  sign-extended immediate
- rd, rs1, rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20]
- opcode7  out  7  inst[6:0]
- opcode3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
- rd_we  out  1  instruction writes rd (rd != 0)
- illegal  out  1  unrecognised encoding

Behaviour:
- Reset: all outputs 0, including out_valid = 0 and fmt = 0.
- in_ready = !flush && (!out_valid || out_ready), purely combinational.
- Accept = in_valid && in_ready. On accept, all output registers load next edge and out_valid = 1.
  - Latency: 1 cycle.
  - Full throughput when out_ready is held high.
- Hold: out_valid && !out_ready -> every output is held bit-stable and nothing is accepted.
- Drain: out_valid && out_ready && !in_valid -> out_valid = 0 next cycle; data registers keep their last value (don't-care).
- Flush: out_valid = 0 next cycle regardless of out_ready; input is not accepted.
  - Flush has priority over accept.
  - rst has priority over flush.
- Format decode (on opcode7):
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else, or inst[1:0] != 2'b11 -> illegal (fmt = 7, illegal = 1, imm = 0, rd_we = 0).
- Immediate, each sign-extended from its top bit to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - R: 0
- rd_we = 1 for R/I/U/J when rd != 0; otherwise 0 (S, B, illegal, and rd = x0).
- Raw fields (rd, rs1, rs2, opcode7, opcode3, funct7) always carry the instruction bits, independent of format.
- No combinational path from inst to any output; outputs come from registers only.

Test Plan:
- Reset/flush: rst high 2 cycles mid-stream -> all outputs 0, out_valid 0. Then out_valid=1 with out_ready=0 and flush=1 for 1 cycle -> out_valid 0 next cycle, and the inst presented that cycle is not captured.
- I-type: inst 0xFFF00093 (addi x1,x0,-1) -> next cycle imm 0xFFFFFFFF, rd 1, rs1 0, fmt 1, rd_we 1. S-type: inst 0x0020A423 (sw x2,8(x1)) -> imm 0x00000008, rs1 1, rs2 2, fmt 2, rd_we 0.
- B-type: inst 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt 3. U-type: inst 0x123452B7 (lui x5) -> imm 0x12345000, rd 5, fmt 4. J-type: inst 0x001000EF (jal x1,+2048) -> imm 0x00000800, fmt 5, rd_we 1.
- Illegal: inst 0x00000000 -> fmt 7, illegal 1, imm 0, rd_we 0. Same check for opcode 0x7F.
- Backpressure: stream 4 instructions with in_valid=1; toggle out_ready 1,0,0,1,1,1 -> outputs stable during stalls, in_ready low during stalls, every instruction delivered exactly once and in order.
- XLEN=64 build: 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF. 0x123452B7 -> imm 0x0000000012345000.
